// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, register width, MEM/WB bundle.
// Optional misaligned-load trap is enabled with MISALIGN_TRAP_EN.
package mips_pkg;

    localparam int REG_AW = 5;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [REG_AW-1:0] write_reg;
        logic [31:0]       result;
    } mem_wb_t;

    function automatic logic is_misaligned(
        input logic [5:0] op,
        input logic [1:0] addr
    );
        return ((op == OP_LH || op == OP_LHU) && addr[0])
            || (op == OP_LW && addr != 2'b00);
    endfunction

endpackage

// File: rtl/load_align.sv
// Byte/halfword lane extraction and sign/zero extension for loads.
// Unknown opcodes pass the raw memory word through.
module load_align
    import mips_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[{addr, 3'b000} +: 8];
        half_lane = addr[1] ? word[31:16] : word[15:0];
        data      = word;
        unique case (1'b1)
            (op == OP_LB):  data = {{24{byte_lane[7]}}, byte_lane};
            (op == OP_LBU): data = {24'h0, byte_lane};
            (op == OP_LH):  data = {{16{half_lane[15]}}, half_lane};
            (op == OP_LHU): data = {16'h0, half_lane};
            default:        data = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM-to-WB pipeline register with load extension and retire counter.
// Define MISALIGN_TRAP_EN to add the misalignW trap output.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int          CNT_W        = 32,
    parameter logic [31:0] RESET_PC_TAG = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallW,
    input  logic              flushW,
    input  logic              validM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic [5:0]        opM,
    input  logic [31:0]       alu_outM,
    input  logic [31:0]       doutbM,
    input  logic [REG_AW-1:0] WriteRegM,
    output logic              validW,
    output logic              RegWriteW,
    output logic [REG_AW-1:0] WriteRegW,
    output logic [31:0]       resultW,
`ifdef MISALIGN_TRAP_EN
    output logic              misalignW,
`endif
    output logic [CNT_W-1:0]  retired_cnt
);

    mem_wb_t     w_q;
    logic [31:0] load_data;
    logic [31:0] next_result;
    logic        wr_ok;

    load_align u_load_align (
        .op   (opM),
        .addr (alu_outM[1:0]),
        .word (doutbM),
        .data (load_data)
    );

    assign next_result = MemtoRegM ? load_data : alu_outM;

`ifdef MISALIGN_TRAP_EN
    logic mis_q;
    logic mis_d;

    assign mis_d     = validM & is_misaligned(opM, alu_outM[1:0]);
    assign wr_ok     = RegWriteM & validM & ~mis_d;
    assign misalignW = mis_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else if (flushW) begin
            mis_q <= 1'b0;
        end else if (!stallW) begin
            mis_q <= mis_d;
        end
    end
`else
    assign wr_ok = RegWriteM & validM;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q.valid     <= 1'b0;
            w_q.reg_write <= 1'b0;
            w_q.write_reg <= '0;
            w_q.result    <= RESET_PC_TAG;
        end else if (flushW) begin
            w_q.valid     <= 1'b0;
            w_q.reg_write <= 1'b0;
        end else if (!stallW) begin
            w_q.valid     <= validM;
            w_q.reg_write <= wr_ok;
            w_q.write_reg <= WriteRegM;
            w_q.result    <= next_result;
        end
    end

    // A flush overrides a stall, so the W occupant leaves and is counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt <= '0;
        end else if (w_q.valid && (!stallW || flushW)) begin
            retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

    assign validW    = w_q.valid;
    assign RegWriteW = w_q.reg_write;
    assign WriteRegW = w_q.write_reg;
    assign resultW   = w_q.result;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table plus scoreboard.
// Builds with or without MISALIGN_TRAP_EN.
module tb_mem_wb_stage;
    import mips_pkg::*;

    localparam int          CW   = 4;
    localparam logic [31:0] RTAG = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst, stallW, flushW, validM, RegWriteM, MemtoRegM;
    logic [5:0]  opM;
    logic [31:0] alu_outM, doutbM;
    logic [4:0]  WriteRegM;
    logic        validW, RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] resultW;
    logic [CW-1:0] retired_cnt;
`ifdef MISALIGN_TRAP_EN
    logic        misalignW;
`endif

    mem_wb_stage #(.CNT_W(CW), .RESET_PC_TAG(RTAG)) dut (
        .clk         (clk),
        .rst         (rst),
        .stallW      (stallW),
        .flushW      (flushW),
        .validM      (validM),
        .RegWriteM   (RegWriteM),
        .MemtoRegM   (MemtoRegM),
        .opM         (opM),
        .alu_outM    (alu_outM),
        .doutbM      (doutbM),
        .WriteRegM   (WriteRegM),
        .validW      (validW),
        .RegWriteW   (RegWriteW),
        .WriteRegW   (WriteRegW),
        .resultW     (resultW),
`ifdef MISALIGN_TRAP_EN
        .misalignW   (misalignW),
`endif
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic        m2r;
        logic        v;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] alu;
        logic [31:0] dout;
        logic [31:0] res;
    } vec_t;

    typedef struct {
        logic        v;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] res;
        logic        mis;
    } exp_t;

    vec_t    vt[12];
    exp_t    q[$];
    int      total = 0;
    int      bad = 0;
    logic [CW-1:0] cnt_exp = '0;
    logic    vw_exp = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(logic [5:0] op, logic m2r, logic v, logic rw,
                         logic [4:0] wr, logic [31:0] alu, logic [31:0] dout);
        opM = op; MemtoRegM = m2r; validM = v; RegWriteM = rw;
        WriteRegM = wr; alu_outM = alu; doutbM = dout;
    endtask

    task automatic push(logic v, logic rw, logic [4:0] wr,
                        logic [31:0] res, logic mis);
        exp_t e;
        e.v = v; e.rw = rw; e.wr = wr; e.res = res; e.mis = mis;
        q.push_back(e);
    endtask

    // Counter model: the W occupant leaves unless held by a bare stall.
    task automatic tick();
        if (rst) cnt_exp = '0;
        else if (vw_exp && (!stallW || flushW)) cnt_exp = cnt_exp + 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string nm);
        exp_t e;
        if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: scoreboard empty", nm);
            return;
        end
        e = q.pop_front();
        chk({nm, ".validW"},    32'(validW),    32'(e.v));
        chk({nm, ".RegWriteW"}, 32'(RegWriteW), 32'(e.rw));
        chk({nm, ".WriteRegW"}, 32'(WriteRegW), 32'(e.wr));
        chk({nm, ".resultW"},   resultW,        e.res);
        chk({nm, ".retired"},   32'(retired_cnt), 32'(cnt_exp));
`ifdef MISALIGN_TRAP_EN
        chk({nm, ".misalignW"}, 32'(misalignW), 32'(e.mis));
`endif
        vw_exp = e.v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{OP_LB,  1, 1, 1, 5'd3,  32'd2, 32'h80FF_7F01, 32'hFFFF_FFFF};
        vt[1]  = '{OP_LBU, 1, 1, 1, 5'd3,  32'd2, 32'h80FF_7F01, 32'h0000_00FF};
        vt[2]  = '{OP_LH,  1, 1, 1, 5'd4,  32'd2, 32'h8001_7FFE, 32'hFFFF_8001};
        vt[3]  = '{OP_LHU, 1, 1, 1, 5'd4,  32'd0, 32'h8001_7FFE, 32'h0000_7FFE};
        vt[4]  = '{6'h00,  0, 1, 1, 5'd9,  32'h1234_5678, 32'h0, 32'h1234_5678};
        vt[5]  = '{OP_LW,  1, 1, 1, 5'd5,  32'd4, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vt[6]  = '{OP_LB,  1, 1, 1, 5'd6,  32'd0, 32'h80FF_7F01, 32'h0000_0001};
        vt[7]  = '{OP_LB,  1, 1, 1, 5'd6,  32'd3, 32'h80FF_7F01, 32'hFFFF_FF80};
        vt[8]  = '{6'h00,  0, 0, 1, 5'd7,  32'hAAAA_5555, 32'h0, 32'hAAAA_5555};
        vt[9]  = '{6'h00,  0, 1, 1, 5'd0,  32'h0000_0042, 32'h0, 32'h0000_0042};
        vt[10] = '{OP_LHU, 1, 1, 1, 5'd8,  32'd2, 32'h8001_7FFE, 32'h0000_8001};
        vt[11] = '{OP_LH,  1, 1, 1, 5'd8,  32'd0, 32'h8001_7FFE, 32'h0000_7FFE};

        rst = 1'b1; stallW = 1'b0; flushW = 1'b0;
        drive(6'h00, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        push(0, 0, 5'd0, RTAG, 0);
        tick();
        check("reset");
        rst = 1'b0;

        foreach (vt[i]) begin
            drive(vt[i].op, vt[i].m2r, vt[i].v, vt[i].rw,
                  vt[i].wr, vt[i].alu, vt[i].dout);
            push(vt[i].v, vt[i].rw & vt[i].v, vt[i].wr, vt[i].res, 0);
            tick();
            check($sformatf("vec%0d", i));
        end

        // Stall holds W while M keeps changing.
        drive(OP_LB, 1, 1, 1, 5'd3, 32'd2, 32'h80FF_7F01);
        push(1, 1, 5'd3, 32'hFFFF_FFFF, 0);
        tick();
        check("pre_stall");
        stallW = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(OP_LW, 1, 1, 1, 5'd12, $urandom & 32'hFFFF_FFFC, $urandom);
            push(1, 1, 5'd3, 32'hFFFF_FFFF, 0);
            tick();
            check($sformatf("stall%0d", k));
        end
        flushW = 1'b1;
        push(0, 0, 5'd3, 32'hFFFF_FFFF, 0);
        tick();
        check("flush_stall");
        stallW = 1'b0; flushW = 1'b0;

        // Valid stream up to the counter wrap point.
        for (int k = 0; k < 40 && cnt_exp != '1; k++) begin
            drive(6'h00, 0, 1, 1, 5'd10, 32'(k), 32'h0);
            push(1, 1, 5'd10, 32'(k), 0);
            tick();
            check("fill");
        end
        chk("cnt_full", 32'(retired_cnt), 32'(2**CW - 1));
        drive(6'h00, 0, 1, 1, 5'd11, 32'h77, 32'h0);
        push(1, 1, 5'd11, 32'h77, 0);
        tick();
        check("wrap");
        chk("cnt_wrap", 32'(retired_cnt), 32'd0);

        // Reset wins over simultaneous stall and flush.
        drive(6'h00, 0, 1, 1, 5'd13, 32'h55, 32'h0);
        rst = 1'b1; stallW = 1'b1; flushW = 1'b1;
        push(0, 0, 5'd0, RTAG, 0);
        tick();
        check("mid_reset");
        rst = 1'b0; stallW = 1'b0; flushW = 1'b0;
        push(1, 1, 5'd13, 32'h55, 0);
        tick();
        check("post_reset");

`ifdef MISALIGN_TRAP_EN
        drive(OP_LW, 1, 1, 1, 5'd14, 32'h6, 32'h1122_3344);
        push(1, 0, 5'd14, 32'h1122_3344, 1);
        tick();
        check("lw_mis");
        drive(OP_LW, 1, 1, 1, 5'd14, 32'h8, 32'h5566_7788);
        push(1, 1, 5'd14, 32'h5566_7788, 0);
        tick();
        check("lw_ok");
        drive(OP_LH, 1, 1, 1, 5'd15, 32'h1, 32'h8001_7FFE);
        push(1, 0, 5'd15, 32'h0000_7FFE, 1);
        tick();
        check("lh_mis");
        flushW = 1'b1;
        push(0, 0, 5'd15, 32'h0000_7FFE, 0);
        tick();
        check("mis_flush");
        flushW = 1'b0;
`else
        drive(OP_LW, 1, 1, 1, 5'd14, 32'h6, 32'h1122_3344);
        push(1, 1, 5'd14, 32'h1122_3344, 0);
        tick();
        check("lw_unal");
        drive(OP_LH, 1, 1, 1, 5'd15, 32'h1, 32'h8001_7FFE);
        push(1, 1, 5'd15, 32'h0000_7FFE, 0);
        tick();
        check("lh_unal");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
